mdio_controller: RTL and testbench
==================================

# mdio_controller

Station-management (STA) side MDIO master. Sits directly upstream of `mdio_receptor`. Takes a 32-bit management frame from the host, generates `MDC`, and serialises the frame MSB-first onto `MDIO_OUT`/`MDIO_OE`. For read frames it releases the bus after the turnaround bits, captures the 16 data bits the PHY returns on `MDIO_IN`, and presents them as `RD_DATA`.

## Interface

Parameters:
- `DIV_HALF`, default 2: number of `CLK` cycles per `MDC` half-period. Must be ≥ 1. One MDIO bit lasts 2·`DIV_HALF` `CLK` cycles.

Ports:
- `CLK` in 1: system clock. Single clock domain.
- `RESET` in 1: asynchronous, active-high reset.
- `MDIO_START` in 1: request a transaction. Accepted only in IDLE.
- `T_DATA` in 32: frame fields.
  - [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data.
- `MDIO_IN` in 1: serial data driven by the PHY (`mdio_receptor` `MDIO_IN`).
- `MDC` out 1: management clock to the PHY.
- `MDIO_OUT` out 1: serial data toward the PHY.
- `MDIO_OE` out 1: high while this block drives `MDIO_OUT`.
- `MDIO_BUSY` out 1: high from acceptance until the frame completes.
- `RD_DATA` out 16: data captured from the last completed read.
- `DATA_RDY` out 1: single-`CLK` pulse when `RD_DATA` is updated.

## Operation

- **Reset values:** all outputs are 0 (`MDC`, `MDIO_OUT`, `MDIO_OE`, `MDIO_BUSY`, `RD_DATA`, `DATA_RDY`). State is IDLE, all counters are 0.
- **Frame types:**
  - OP = 2'b10 is a read.
  - Any other OP value is treated as a write (the full 32 bits are driven). No validity checking of ST or OP is performed.
- **State machine:**
  - IDLE: `MDC`=0, `MDIO_OE`=0, `MDIO_OUT`=0. On a `CLK` edge with `MDIO_START`=1:
    - latch `T_DATA` into the shift register, store the read flag;
    - set `MDIO_OE`=1, `MDIO_OUT`=`T_DATA[31]`, `MDIO_BUSY`=1;
    - clear `bit_cnt` and the divider; go to XFER.
  - XFER: the divider counts 0..`DIV_HALF`-1. At each wrap, `MDC` toggles.
    - Rising event (`MDC` 0→1): if read and `bit_cnt` ≥ 16, shift `MDIO_IN` into the capture register, MSB first. Bit 16 of the frame ends up in `RD_DATA[15]`.
    - Falling event (`MDC` 1→0):
      - If `bit_cnt`=31: go to DONE.
      - Otherwise: increment `bit_cnt` and drive the next frame bit on `MDIO_OUT`.
      - If read and the new `bit_cnt`=16: drop `MDIO_OE` to 0 and hold `MDIO_OUT`=0 for the rest of the frame.
  - DONE (one `CLK`):
    - `MDC`=0, `MDIO_OE`=0, `MDIO_OUT`=0, `MDIO_BUSY`=0.
    - If read: load `RD_DATA` from the capture register and pulse `DATA_RDY` for this cycle.
    - Return to IDLE.
- **Data phase:** in a read frame, `T_DATA[15:0]` is ignored. In a write frame, `RD_DATA` is untouched.
- **Start during busy:** `MDIO_START` asserted in XFER or DONE is ignored, not queued. The host must re-assert it once `MDIO_BUSY`=0.
- **Reset mid-operation:** asynchronously returns to the reset values. A partially captured `RD_DATA` is never exposed and `DATA_RDY` does not pulse.
- `MDC` is stopped (held low) while idle. Every frame starts with a full low half-period.

## Timing

- `MDIO_OUT` changes only on `MDC` falling events, or at acceptance. It is therefore stable across each `MDC` rising edge, where the PHY samples it.
- **Bit i (i=0 for frame MSB):** driven from `CLK` edge 2·`DIV_HALF`·i after acceptance. `MDC` rises `DIV_HALF` cycles later.
- **Read, `MDIO_OE` low:** from 32·`DIV_HALF` cycles after acceptance (falling event 16).
- **DONE entered:** 64·`DIV_HALF` cycles after acceptance. `DATA_RDY` is high in the following cycle.
- **`MDIO_BUSY`:** high for 64·`DIV_HALF`+1 cycles.
- **Back-to-back:** the earliest next acceptance is the cycle after DONE. The minimum frame-to-frame spacing is 64·`DIV_HALF`+2 cycles.
- **`MDIO_IN`:** sampled synchronously to `CLK` at the rising-event cycle. The bench must hold it stable for that `CLK` edge.

## Test plan

- **Write, `DIV_HALF`=2:** `T_DATA`=0x5B5743AE, start pulse.
  - `MDIO_OUT` sampled at 32 `MDC` rising edges reproduces 0x5B5743AE MSB-first.
  - `MDIO_OE`=1 for exactly 128 `CLK`.
  - `DATA_RDY` never pulses and `RD_DATA` stays 0.
- **Read with PHY model:** `T_DATA`=0x6077_0000 (OP=10), PHY model drives 0x43AE during bits 16..31.
  - `MDIO_OE` falls 64 `CLK` after acceptance.
  - `RD_DATA`=0x43AE and `DATA_RDY` is a single pulse at 129 `CLK` after acceptance.
- **Start while busy:** pulse `MDIO_START` with a different `T_DATA` mid-write.
  - The frame in progress is unchanged and no second frame follows.
- **Reset mid-read:** assert `RESET` at bit 20 of a read.
  - All outputs go to 0 immediately.
  - A subsequent read of 0xFFFF returns 0xFFFF with no stale bits.
- **Back-to-back:** two reads (0x1234, then 0xA5A5) with the second start held high.
  - Second acceptance happens the cycle after the first DONE.
  - Two `DATA_RDY` pulses occur with the correct values in order.
- **`DIV_HALF`=1:** repeat the write case.
  - `MDC` period is 2 `CLK` and the frame completes in 64 `CLK`.

Source files
------------

// File: rtl/mdio_controller.sv
// MDIO station-management master: generates MDC, shifts a 32-bit frame out MSB-first,
// and for read frames releases the bus after the turnaround and captures 16 data bits.
module mdio_controller #(
  parameter int DIV_HALF = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic        MDIO_BUSY,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [4:0]    bit_cnt;
  logic [30:0]   shreg;
  logic          rd;
  logic [15:0]   cap;
  logic          wrap;

  assign wrap = (div == DW'(DIV_HALF - 1));

  // NOTE: every register, including the shift and capture registers, is reset so a
  // reset mid-frame can never leave stale read bits behind.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rd        <= 1'b0;
      cap       <= '0;
      MDC       <= 1'b0;
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      MDIO_BUSY <= 1'b0;
      RD_DATA   <= '0;
      DATA_RDY  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
      DATA_RDY <= 1'b0;
      case (state)
        IDLE: begin
          MDC      <= 1'b0;
          MDIO_OE  <= 1'b0;
          MDIO_OUT <= 1'b0;
          if (MDIO_START) begin
            shreg     <= T_DATA[30:0];
            rd        <= (T_DATA[29:28] == 2'b10);
            cap       <= '0;
            MDIO_OE   <= 1'b1;
            MDIO_OUT  <= T_DATA[31];
            MDIO_BUSY <= 1'b1;
            bit_cnt   <= '0;
            div       <= '0;
            state     <= XFER;
          end
        end

        XFER: begin
          if (!wrap) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            MDC <= ~MDC;
            if (!MDC) begin
              // rising event: PHY-driven data bits 16..31 land MSB first
              if (rd && bit_cnt[4])
                cap <= {cap[14:0], MDIO_IN};
            end else if (bit_cnt == 5'd31) begin
              MDIO_OE  <= 1'b0;
              MDIO_OUT <= 1'b0;
              state    <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[29:0], 1'b0};
              // read frames release the bus once the turnaround bits are out
              if (rd && bit_cnt >= 5'd15) begin
                MDIO_OE  <= 1'b0;
                MDIO_OUT <= 1'b0;
              end else begin
                MDIO_OUT <= shreg[30];
              end
            end
          end
        end

        DONE: begin
          MDC       <= 1'b0;
          MDIO_OE   <= 1'b0;
          MDIO_OUT  <= 1'b0;
          MDIO_BUSY <= 1'b0;
          if (rd) begin
            RD_DATA  <= cap;
            DATA_RDY <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_controller.sv
// Scoreboard bench for mdio_controller: expected frames and read data are queued at
// stimulus time and checked by a negedge monitor that also plays the PHY.
module tb_mdio_controller;

  typedef struct {
    logic [31:0] frame;
    logic        is_rd;
  } frame_t;

  localparam int DH = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start0, start1;
  logic [31:0] tdata0, tdata1;
  logic        mdio_in0;
  logic        mdc0, out0, oe0, busy0, rdy0;
  logic        mdc1, out1, oe1, busy1, rdy1;
  logic [15:0] rd0, rd1;

  int tests = 0;
  int fails = 0;

  frame_t      exp_frames[$];
  logic [15:0] exp_rd[$];
  logic [15:0] phy_word = '0;

  logic [31:0] cap_frame;
  int          n_rise, busy_cyc, oe_cyc, t_acc;
  logic        busy_q, mdc_q, rdy_q;

  always #5 CLK = ~CLK;

  mdio_controller #(.DIV_HALF(DH)) dut0 (
    .CLK(CLK), .RESET(RESET), .MDIO_START(start0), .T_DATA(tdata0), .MDIO_IN(mdio_in0),
    .MDC(mdc0), .MDIO_OUT(out0), .MDIO_OE(oe0), .MDIO_BUSY(busy0),
    .RD_DATA(rd0), .DATA_RDY(rdy0)
  );

  mdio_controller #(.DIV_HALF(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .MDIO_START(start1), .T_DATA(tdata1), .MDIO_IN(1'b0),
    .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1), .MDIO_BUSY(busy1),
    .RD_DATA(rd1), .DATA_RDY(rdy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor and PHY model for dut0
  always @(negedge CLK) begin
    if (RESET) begin
      busy_q   = 1'b0;
      mdc_q    = 1'b0;
      rdy_q    = 1'b0;
      n_rise   = 0;
      t_acc    = 0;
      mdio_in0 = 1'b0;
    end else begin
      if (busy0 && !busy_q) begin
        cap_frame = '0;
        n_rise    = 0;
        busy_cyc  = 0;
        oe_cyc    = 0;
        t_acc     = 0;
      end else begin
        t_acc++;
      end
      if (busy0) busy_cyc++;
      if (oe0) oe_cyc++;
      if (mdc0 && !mdc_q) begin
        cap_frame = {cap_frame[30:0], oe0 ? out0 : 1'b0};
        n_rise++;
      end
      if (!busy0 && busy_q) begin
        if (exp_frames.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_unexpected: got frame %h, expected none", cap_frame);
        end else begin
          frame_t e;
          e = exp_frames.pop_front();
          check("frame_bits", cap_frame, e.frame);
          check("frame_rises", n_rise, 32);
          check("busy_cycles", busy_cyc, 64 * DH + 1);
          check("oe_cycles", oe_cyc, e.is_rd ? 32 * DH : 64 * DH);
        end
      end
      if (rdy0) begin
        check("rdy_single", rdy_q, 0);
        check("rdy_time", t_acc, 64 * DH + 1);
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rdy_unexpected: got RD_DATA %h, expected no pulse", rd0);
        end else begin
          check("rd_data", rd0, exp_rd.pop_front());
        end
      end
      mdio_in0 = (busy0 && n_rise >= 16 && n_rise < 32) ? phy_word[31 - n_rise] : 1'b0;
      busy_q = busy0;
      mdc_q  = mdc0;
      rdy_q  = rdy0;
    end
  end

  task automatic push_frame(input logic [31:0] t);
    frame_t f;
    f.is_rd = (t[29:28] == 2'b10);
    f.frame = f.is_rd ? {t[31:16], 16'h0} : t;
    exp_frames.push_back(f);
  endtask

  task automatic start_frame(input logic [31:0] t);
    @(negedge CLK);
    tdata0 = t;
    start0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (busy0 === level) break;
    end
    if (k == 2000) check(name, busy0, level);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mdc"}, mdc0, 0);
    check({tag, "_out"}, out0, 0);
    check({tag, "_oe"}, oe0, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_rd"}, rd0, 0);
    check({tag, "_rdy"}, rdy0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_seen, oe_seen, rise_seen, high_seen, rdy_seen;
    logic [31:0] f1;
    logic m1q;

    RESET = 1'b1; start0 = 0; start1 = 0; tdata0 = '0; tdata1 = '0;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RESET = 1'b0;

    // Write frame
    push_frame(32'h5B5743AE);
    start_frame(32'h5B5743AE);
    wait_busy(1'b0, "wr_timeout");
    check("wr_rd_untouched", rd0, 0);

    // Start while busy is ignored, not queued
    push_frame(32'h51234567);
    start_frame(32'h51234567);
    repeat (40) @(negedge CLK);
    tdata0 = 32'h6FFF_FFFF;
    start0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
    tdata0 = '0;
    wait_busy(1'b0, "busy_start_timeout");
    busy_seen = 0;
    repeat (300) begin
      @(negedge CLK);
      if (busy0) busy_seen++;
    end
    check("no_second_frame", busy_seen, 0);

    // Read with PHY model
    phy_word = 16'h43AE;
    push_frame(32'h6077_0000);
    exp_rd.push_back(16'h43AE);
    start_frame(32'h6077_0000);
    wait_busy(1'b0, "rd_timeout");
    repeat (3) @(negedge CLK);

    // Reset mid-read at bit 20
    phy_word = 16'h5555;
    start_frame(32'h6077_0000);
    for (int k = 0; k < 2000 && n_rise < 20; k++) @(negedge CLK);
    #1 RESET = 1'b1;
    #1 check_outputs_zero("midrst");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    phy_word = 16'hFFFF;
    push_frame(32'h6077_0000);
    exp_rd.push_back(16'hFFFF);
    start_frame(32'h6077_0000);
    wait_busy(1'b0, "rd_ffff_timeout");
    repeat (3) @(negedge CLK);

    // Back-to-back reads with start held high
    phy_word = 16'h1234;
    push_frame(32'h6077_0000);
    push_frame(32'h6077_0000);
    exp_rd.push_back(16'h1234);
    exp_rd.push_back(16'hA5A5);
    @(negedge CLK);
    tdata0 = 32'h6077_0000;
    start0 = 1'b1;
    wait_busy(1'b1, "b2b_first_timeout");
    wait_busy(1'b0, "b2b_done_timeout");
    phy_word = 16'hA5A5;
    @(negedge CLK);
    check("b2b_accept", busy0, 1);
    start0 = 1'b0;
    wait_busy(1'b0, "b2b_second_timeout");
    repeat (5) @(negedge CLK);

    // DIV_HALF = 1 write on dut1
    @(negedge CLK);
    tdata1 = 32'h5B5743AE;
    start1 = 1'b1;
    f1 = '0; busy_seen = 0; oe_seen = 0; rise_seen = 0; high_seen = 0; rdy_seen = 0;
    m1q = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      start1 = 1'b0;
      if (busy1) busy_seen++;
      if (oe1) oe_seen++;
      if (mdc1) high_seen++;
      if (rdy1) rdy_seen++;
      if (mdc1 && !m1q) begin
        f1 = {f1[30:0], out1};
        rise_seen++;
      end
      m1q = mdc1;
    end
    check("dh1_frame_bits", f1, 32'h5B5743AE);
    check("dh1_rises", rise_seen, 32);
    check("dh1_mdc_high", high_seen, 32);
    check("dh1_oe_cycles", oe_seen, 64);
    check("dh1_busy_cycles", busy_seen, 65);
    check("dh1_no_rdy", rdy_seen, 0);
    check("dh1_rd_untouched", rd1, 0);

    check("frames_left", exp_frames.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
